// File: rtl/prng_sponge.sv
// rtl/prng_sponge.sv - duplex-sponge DRBG over a 200-bit state driving an external permutation core
//
// Purpose:
//   Keeps a persistent 200-bit sponge state. Seeds are absorbed into the top RATE
//   bits (init zeroes the state first, reseed XORs into it). Generate requests
//   squeeze gen_nblk RATE-bit blocks, one permutation per block. Each request ends
//   with a refresh permutation so earlier output cannot be recomputed from the state.
//   The permutation itself lives outside this block behind a start/done handshake.
//
// Ports:
//   clk, rst_b                      clock, asynchronous active-low reset
//   seed_valid/seed_ready           seed handshake; seed_mode 1 = reseed, 0 = init
//   seed_data[RATE]                 seed, byte k lands on state[199-8k -: 8]
//   gen_req, gen_nblk[CNT_W]        single-cycle generate request and block count
//   gen_err                         one-cycle pulse when a request is refused
//   out_valid/out_ready/out_last    output block handshake, last marks final block
//   out_data[RATE]                  state[199 -: RATE]
//   perm_start/perm_state[200]      start pulse and input to the permutation core
//   perm_done/perm_result[200]      result-valid pulse and output from the core
//   seeded, reseed_req, busy        status

module prng_sponge #(
  parameter int RATE    = 96,
  parameter int CNT_W   = 8,
  parameter int MAX_BLK = 1024,
  parameter int BLK_W   = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             seed_valid,
  input  logic             seed_mode,
  input  logic [RATE-1:0]  seed_data,
  output logic             seed_ready,
  input  logic             gen_req,
  input  logic [CNT_W-1:0] gen_nblk,
  output logic             gen_err,
  output logic             out_valid,
  output logic [RATE-1:0]  out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             perm_start,
  output logic [199:0]     perm_state,
  input  logic             perm_done,
  input  logic [199:0]     perm_result,
  output logic             seeded,
  output logic             reseed_req,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_PERM,
    S_SQ_PERM,
    S_SQ_OUT,
    S_FIN_PERM
  } fsm_t;

  localparam logic [BLK_W-1:0] BLK_SAT = {BLK_W{1'b1}};

  fsm_t             fsm_q, fsm_d;
  logic [199:0]     state_q, state_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             seeded_q, seeded_d;
  logic             perm_start_q, perm_start_d;
  logic             gen_err_q, gen_err_d;
  // Holds seed_ready low while reset is asserted and for the first cycle after,
  // so every output reads 0 during reset.
  logic             live_q, live_d;

  logic [199:0]     seed_map;

  // Seed byte k goes to the k-th byte from the top of the state.
  always_comb begin
    seed_map = '0;
    for (int k = 0; k < RATE / 8; k++) begin
      seed_map[199-8*k -: 8] = seed_data[8*k +: 8];
    end
  end

  assign reseed_req = (blk_cnt_q >= BLK_W'(MAX_BLK));

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    remaining_d  = remaining_q;
    seeded_d     = seeded_q;
    perm_start_d = 1'b0;
    gen_err_d    = 1'b0;
    live_d       = 1'b1;

    case (fsm_q)
      S_IDLE: begin
        // A seed takes priority; a simultaneous gen_req is silently dropped.
        if (seed_valid && live_q) begin
          state_d      = (seed_mode ? state_q : 200'd0) ^ seed_map;
          blk_cnt_d    = '0;
          seeded_d     = 1'b1;
          perm_start_d = 1'b1;
          fsm_d        = S_ABS_PERM;
        end else if (gen_req) begin
          if ((gen_nblk == '0) || !seeded_q || reseed_req) begin
            gen_err_d = 1'b1;
          end else begin
            remaining_d  = gen_nblk;
            perm_start_d = 1'b1;
            fsm_d        = S_SQ_PERM;
          end
        end
      end
      S_ABS_PERM: begin
        if (perm_done) begin
          state_d = perm_result;
          fsm_d   = S_IDLE;
        end
      end
      S_SQ_PERM: begin
        if (perm_done) begin
          state_d = perm_result;
          fsm_d   = S_SQ_OUT;
        end
      end
      S_SQ_OUT: begin
        if (out_ready) begin
          if (blk_cnt_q != BLK_SAT) begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
          end
          remaining_d  = remaining_q - CNT_W'(1);
          perm_start_d = 1'b1;
          // The last block is followed by a refresh permutation before IDLE.
          fsm_d        = (remaining_q > CNT_W'(1)) ? S_SQ_PERM : S_FIN_PERM;
        end
      end
      S_FIN_PERM: begin
        if (perm_done) begin
          state_d = perm_result;
          fsm_d   = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      fsm_q        <= S_IDLE;
      state_q      <= '0;
      blk_cnt_q    <= '0;
      remaining_q  <= '0;
      seeded_q     <= 1'b0;
      perm_start_q <= 1'b0;
      gen_err_q    <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      remaining_q  <= remaining_d;
      seeded_q     <= seeded_d;
      perm_start_q <= perm_start_d;
      gen_err_q    <= gen_err_d;
      live_q       <= live_d;
    end
  end

  assign seed_ready = (fsm_q == S_IDLE) && live_q;
  assign busy       = (fsm_q != S_IDLE);
  assign out_valid  = (fsm_q == S_SQ_OUT);
  assign out_data   = state_q[199 -: RATE];
  assign out_last   = out_valid && (remaining_q == CNT_W'(1));
  assign perm_start = perm_start_q;
  assign perm_state = state_q;
  assign gen_err    = gen_err_q;
  assign seeded     = seeded_q;

endmodule

// File: tb/tb_prng_sponge.sv
// tb/tb_prng_sponge.sv - randomized self-checking bench for prng_sponge against a sponge reference model

module tb_prng_sponge;

  localparam int RATE    = 96;
  localparam int CNT_W   = 8;
  localparam int MAX_BLK = 4;
  localparam int BLK_W   = 16;
  localparam int LAT     = 18;

  logic             clk;
  logic             rst_b;
  logic             seed_valid;
  logic             seed_mode;
  logic [RATE-1:0]  seed_data;
  logic             seed_ready;
  logic             gen_req;
  logic [CNT_W-1:0] gen_nblk;
  logic             gen_err;
  logic             out_valid;
  logic [RATE-1:0]  out_data;
  logic             out_last;
  logic             out_ready;
  logic             perm_start;
  logic [199:0]     perm_state;
  logic             perm_done;
  logic [199:0]     perm_result;
  logic             seeded;
  logic             reseed_req;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: sponge state, blocks since last seed, seeded flag.
  logic [199:0] m_state;
  int           m_cnt;
  logic         m_seeded;

  prng_sponge #(.RATE(RATE), .CNT_W(CNT_W), .MAX_BLK(MAX_BLK), .BLK_W(BLK_W)) dut (
    .clk(clk), .rst_b(rst_b),
    .seed_valid(seed_valid), .seed_mode(seed_mode), .seed_data(seed_data), .seed_ready(seed_ready),
    .gen_req(gen_req), .gen_nblk(gen_nblk), .gen_err(gen_err),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .perm_start(perm_start), .perm_state(perm_state), .perm_done(perm_done), .perm_result(perm_result),
    .seeded(seeded), .reseed_req(reseed_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Permutation core stand-in: result = ~input, done LAT cycles after start.
  initial begin
    logic [199:0] cap;
    perm_done   = 1'b0;
    perm_result = '0;
    forever begin
      @(negedge clk);
      if (perm_start === 1'b1) begin
        cap = perm_state;
        repeat (LAT) @(negedge clk);
        perm_done   = 1'b1;
        perm_result = ~cap;
        @(negedge clk);
        perm_done   = 1'b0;
        perm_result = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [199:0] absorb(input logic [199:0] st, input logic [RATE-1:0] sd, input logic mode);
    logic [199:0] r;
    r = mode ? st : 200'd0;
    for (int k = 0; k < RATE / 8; k++) r[199-8*k -: 8] = r[199-8*k -: 8] ^ sd[8*k +: 8];
    return r;
  endfunction

  // Offer a seed (optionally with a colliding gen_req) and follow the absorb permutation.
  task automatic do_seed(input logic [RATE-1:0] sd, input logic mode, input logic with_gen);
    int cyc;
    if (seed_ready !== 1'b1) begin n_err++; $display("FAIL seed_ready_idle: got %b want 1", seed_ready); end
    n_cmp++;
    seed_valid = 1'b1; seed_data = sd; seed_mode = mode;
    gen_req = with_gen; gen_nblk = with_gen ? CNT_W'(2) : CNT_W'(0);
    @(negedge clk);
    seed_valid = 1'b0; gen_req = 1'b0;
    m_state = absorb(m_state, sd, mode); m_cnt = 0; m_seeded = 1'b1;
    if ({perm_start, seed_ready, busy, gen_err, seeded} !== 5'b10101) begin
      n_err++; $display("FAIL seed_t1_flags: got %b want 10101", {perm_start, seed_ready, busy, gen_err, seeded});
    end
    n_cmp++;
    if (perm_state !== m_state) begin n_err++; $display("FAIL absorb_state: got %h want %h", perm_state, m_state); end
    n_cmp++;
    cyc = 0;
    while (busy && cyc < 100) begin @(negedge clk); cyc++; end
    if (cyc !== LAT + 1) begin n_err++; $display("FAIL absorb_cycles: got %0d want %0d", cyc, LAT + 1); end
    n_cmp++;
    m_state = ~m_state;
    if (perm_state !== m_state) begin n_err++; $display("FAIL absorb_result: got %h want %h", perm_state, m_state); end
    n_cmp++;
  endtask

  // Run one generate request; block stall_blk is held off for stall_len cycles.
  task automatic do_gen(input int nblk, input int stall_blk, input int stall_len, output int done_cyc);
    int cyc, blk, stall, first_valid, extra;
    logic seen;
    gen_req = 1'b1; gen_nblk = CNT_W'(nblk); out_ready = 1'b1;
    @(negedge clk);
    gen_req = 1'b0;
    if ({perm_start, gen_err, busy} !== 3'b101) begin
      n_err++; $display("FAIL gen_t1_flags: got %b want 101", {perm_start, gen_err, busy});
    end
    n_cmp++;
    cyc = 0; blk = 0; stall = 0; first_valid = -1; seen = 1'b0;
    while (blk < nblk && cyc < 2000) begin
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (!seen) begin
          seen = 1'b1;
          m_state = ~m_state;
          if (out_last !== (blk == nblk - 1)) begin
            n_err++; $display("FAIL out_last blk %0d: got %b want %b", blk, out_last, (blk == nblk - 1));
          end
          n_cmp++;
        end
        if (out_data !== m_state[199 -: RATE]) begin
          n_err++; $display("FAIL out_data blk %0d: got %h want %h", blk, out_data, m_state[199 -: RATE]);
        end
        n_cmp++;
        if (blk == stall_blk && stall < stall_len) begin
          out_ready = 1'b0; stall++;
        end else begin
          out_ready = 1'b1; blk++; seen = 1'b0; m_cnt++;
        end
      end
      @(negedge clk); cyc++;
    end
    if (blk !== nblk) begin n_err++; $display("FAIL block_count: got %0d want %0d", blk, nblk); end
    n_cmp++;
    if (first_valid !== LAT + 1) begin n_err++; $display("FAIL first_latency: got %0d want %0d", first_valid, LAT + 1); end
    n_cmp++;
    extra = 0;
    while (busy && cyc < 4000) begin
      if (out_valid) extra++;
      @(negedge clk); cyc++;
    end
    m_state = ~m_state;
    if (extra !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL extra_blocks: got %0d busy %b want 0 0", extra, busy); end
    n_cmp++;
    if (perm_state !== m_state) begin n_err++; $display("FAIL fin_state: got %h want %h", perm_state, m_state); end
    n_cmp++;
    if (reseed_req !== (m_cnt >= MAX_BLK)) begin
      n_err++; $display("FAIL reseed_req: got %b want %b (cnt %0d)", reseed_req, (m_cnt >= MAX_BLK), m_cnt);
    end
    n_cmp++;
    done_cyc = cyc;
  endtask

  task automatic do_refused(input int nblk);
    gen_req = 1'b1; gen_nblk = CNT_W'(nblk);
    @(negedge clk);
    gen_req = 1'b0;
    if ({gen_err, perm_start, busy} !== 3'b100) begin
      n_err++; $display("FAIL refuse_t1: got %b want 100", {gen_err, perm_start, busy});
    end
    n_cmp++;
    @(negedge clk);
    if ({gen_err, perm_start, busy} !== 3'b000) begin
      n_err++; $display("FAIL refuse_t2: got %b want 000", {gen_err, perm_start, busy});
    end
    n_cmp++;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; seed_valid = 1'b0; seed_mode = 1'b0; seed_data = '0;
    gen_req = 1'b0; gen_nblk = '0; out_ready = 1'b0;
    m_state = '0; m_cnt = 0; m_seeded = 1'b0;
    repeat (3) @(negedge clk);
    if ({seed_ready, gen_err, out_valid, out_last, perm_start, seeded, reseed_req, busy} !== 8'd0 ||
        out_data !== '0 || perm_state !== '0) begin
      n_err++; $display("FAIL reset_outputs: got flags %b state %h want all 0",
        {seed_ready, gen_err, out_valid, out_last, perm_start, seeded, reseed_req, busy}, perm_state);
    end
    n_cmp++;
    rst_b = 1'b1;
    @(negedge clk);
    if ({seed_ready, busy, seeded} !== 3'b100) begin
      n_err++; $display("FAIL post_reset: got %b want 100", {seed_ready, busy, seeded});
    end
    n_cmp++;
  endtask

  task automatic test_refuse_unseeded();
    do_refused(2);
  endtask

  task automatic test_init_seed();
    logic [95:0] want;
    want = ~96'h0102030405060708090A0B0C;
    do_seed(96'h0C0B0A090807060504030201, 1'b0, 1'b0);
    if (perm_state[199:104] !== want) begin
      n_err++; $display("FAIL init_top: got %h want %h", perm_state[199:104], want);
    end
    n_cmp++;
  endtask

  task automatic test_single_block();
    int done_cyc;
    do_gen(1, -1, 0, done_cyc);
    if (done_cyc !== 2 * (LAT + 1) + 1) begin
      n_err++; $display("FAIL single_busy_fall: got %0d want %0d", done_cyc, 2 * (LAT + 1) + 1);
    end
    n_cmp++;
  endtask

  task automatic test_stall_multi();
    int done_cyc;
    do_seed({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    do_gen(3, 1, 5, done_cyc);
    do_gen(1, -1, 0, done_cyc);
  endtask

  task automatic test_refuse_zero();
    do_seed({$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    do_refused(0);
  endtask

  task automatic test_reseed_req();
    int done_cyc;
    do_seed({$urandom, $urandom, $urandom}, 1'b0, 1'b0);
    do_gen(3, 0, 2, done_cyc);
    do_gen(3, 2, 3, done_cyc);
    do_refused(1);
    do_seed({$urandom, $urandom, $urandom}, 1'b1, 1'b0);
    if (reseed_req !== 1'b0) begin n_err++; $display("FAIL reseed_clear: got %b want 0", reseed_req); end
    n_cmp++;
    do_gen(2, 0, 1, done_cyc);
  endtask

  task automatic test_back_to_back();
    int done_cyc, nb;
    for (int i = 0; i < 4; i++) begin
      do_seed({$urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      nb = $urandom_range(1, 3);
      do_gen(nb, $urandom_range(0, nb - 1), $urandom_range(0, 4), done_cyc);
    end
  endtask

  task automatic test_collision_reset();
    int bad, saw_done;
    do_seed({$urandom, $urandom, $urandom}, 1'b1, 1'b1);
    gen_req = 1'b1; gen_nblk = CNT_W'(2); out_ready = 1'b1;
    @(negedge clk);
    gen_req = 1'b0;
    repeat (5) @(negedge clk);
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL pre_abort: got busy %b valid %b want 1 0", busy, out_valid);
    end
    n_cmp++;
    rst_b = 1'b0;
    #1;
    if ({seed_ready, gen_err, out_valid, out_last, perm_start, seeded, reseed_req, busy} !== 8'd0 ||
        perm_state !== '0) begin
      n_err++; $display("FAIL abort_outputs: got %b want 0",
        {seed_ready, gen_err, out_valid, out_last, perm_start, seeded, reseed_req, busy});
    end
    n_cmp++;
    @(negedge clk);
    rst_b = 1'b1;
    m_state = '0; m_cnt = 0; m_seeded = 1'b0;
    bad = 0; saw_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (perm_done) saw_done++;
      if (busy || out_valid || perm_start || seeded || gen_err || perm_state !== '0) bad++;
    end
    if (bad !== 0 || saw_done !== 1) begin
      n_err++; $display("FAIL stray_done: got bad %0d dones %0d want 0 1", bad, saw_done);
    end
    n_cmp++;
    do_refused(1);
  endtask

  initial begin
    test_reset();
    test_refuse_unseeded();
    test_init_seed();
    test_single_block();
    test_stall_multi();
    test_refuse_zero();
    test_reseed_req();
    test_back_to_back();
    test_collision_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
